// File: rtl/countdown_timer.sv
// Loadable down-counter with a programmable prescaler, optional auto-reload
// and a three-state IDLE/RUN/DONE controller with a registered terminal-count pulse.
module countdown_timer #(
   parameter int WIDTH = 5,
   parameter int PRE_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             start,
   input  logic             enab,
   input  logic             ack,
   input  logic             reload,
   input  logic [PRE_W-1:0] prescale,
   input  logic [WIDTH-1:0] cnt_in,
   output logic [WIDTH-1:0] cnt_out,
   output logic             busy,
   output logic             done,
   output logic             tc
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [WIDTH-1:0] CNT_ZERO = '0;
   localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
   localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic             tc_q, tc_d;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         reload_q <= '0;
         pre_q    <= '0;
         tc_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         reload_q <= reload_d;
         pre_q    <= pre_d;
         tc_q     <= tc_d;
      end
   end

   // NOTE: every next-state signal gets a hold/default value first so no path
   // through the case statement can leave it unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      reload_d = reload_q;
      pre_d    = pre_q;
      tc_d     = 1'b0;

      if (load) begin
         cnt_d    = cnt_in;
         reload_d = cnt_in;
         pre_d    = '0;
         state_d  = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  if (cnt_q != CNT_ZERO) begin
                     state_d = ST_RUN;
                     pre_d   = '0;
                  end else begin
                     tc_d    = 1'b1;
                     state_d = ST_DONE;
                  end
               end
            end

            ST_RUN: begin
               if (enab) begin
                  if (pre_q != prescale) begin
                     // Wraps modulo 2^PRE_W when prescale was lowered below it.
                     pre_d = pre_q + PRE_ONE;
                  end else begin
                     pre_d = '0;
                     if (cnt_q == CNT_ONE) begin
                        tc_d = 1'b1;
                        if (reload) begin
                           cnt_d = reload_q;
                        end else begin
                           cnt_d   = CNT_ZERO;
                           state_d = ST_DONE;
                        end
                     end else if (cnt_q != CNT_ZERO) begin
                        cnt_d = cnt_q - CNT_ONE;
                     end
                  end
               end
            end

            ST_DONE: begin
               if (ack) begin
                  state_d = ST_IDLE;
               end
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign cnt_out = cnt_q;
   assign busy    = (state_q == ST_RUN);
   assign done    = (state_q == ST_DONE);
   assign tc      = tc_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios with expectations
// derived from the timer's rules, plus a randomized run against a cycle model.
module tb_countdown_timer;

   localparam int WIDTH = 5;
   localparam int PRE_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             load = 1'b0, start = 1'b0, enab = 1'b0, ack = 1'b0, reload = 1'b0;
   logic [PRE_W-1:0] prescale = '0;
   logic [WIDTH-1:0] cnt_in = '0;
   logic [WIDTH-1:0] cnt_out;
   logic             busy, done, tc;

   int n_cmp = 0;
   int n_err = 0;

   // Behavioural model: mode 0 = idle, 1 = counting, 2 = finished.
   int m_mode = 0;
   int m_cnt  = 0;
   int m_rel  = 0;
   int m_pre  = 0;
   bit m_tc   = 0;

   countdown_timer #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
      .clk(clk), .rst(rst), .load(load), .start(start), .enab(enab), .ack(ack),
      .reload(reload), .prescale(prescale), .cnt_in(cnt_in),
      .cnt_out(cnt_out), .busy(busy), .done(done), .tc(tc)
   );

   always #5 clk = ~clk;

   // Advance the model by one rising edge using the inputs as they stand.
   function automatic void model_edge();
      m_tc = 0;
      if (rst) begin
         m_mode = 0; m_cnt = 0; m_rel = 0; m_pre = 0;
      end else if (load) begin
         m_cnt = int'(cnt_in); m_rel = int'(cnt_in); m_pre = 0; m_mode = 0;
      end else if (m_mode == 0) begin
         if (start && m_cnt == 0) begin
            m_tc = 1; m_mode = 2;
         end else if (start) begin
            m_mode = 1; m_pre = 0;
         end
      end else if (m_mode == 1) begin
         if (enab && m_pre != int'(prescale)) begin
            m_pre = (m_pre + 1) % (1 << PRE_W);
         end else if (enab) begin
            m_pre = 0;
            m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
            if (m_cnt == 0) begin
               m_tc = 1;
               if (reload) m_cnt = m_rel;
               else m_mode = 2;
            end
         end
      end else if (ack) begin
         m_mode = 0;
      end
   endfunction

   function automatic logic [WIDTH+2:0] model_vec();
      return {m_mode == 1, m_mode == 2, m_tc, WIDTH'(m_cnt)};
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_load(input int v);
      load = 1'b1; cnt_in = WIDTH'(v);
      step();
      load = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      n_cmp++;
      if ({busy, done, tc, cnt_out} !== '0) begin
         n_err++; $display("FAIL reset_async got %b want 0", {busy, done, tc, cnt_out});
      end
      step(); step();
      n_cmp++;
      if ({busy, done, tc, cnt_out} !== '0) begin
         n_err++; $display("FAIL reset_held got %b want 0", {busy, done, tc, cnt_out});
      end
      rst = 1'b0;
      step();
      n_cmp++;
      if ({busy, done, tc, cnt_out} !== '0) begin
         n_err++; $display("FAIL reset_release got %b want 0", {busy, done, tc, cnt_out});
      end
   endtask

   task automatic test_basic();
      logic [WIDTH+2:0] want;
      prescale = '0; enab = 1'b1; reload = 1'b0;
      do_load(3);
      do_start();
      n_cmp++;
      if ({busy, done, tc, cnt_out} !== {3'b100, 5'd3}) begin
         n_err++; $display("FAIL basic_busy got %b want %b", {busy, done, tc, cnt_out}, {3'b100, 5'd3});
      end
      for (int i = 2; i >= 0; i--) begin
         step();
         want = (i == 0) ? {3'b011, 5'd0} : {3'b100, 5'(i)};
         n_cmp++;
         if ({busy, done, tc, cnt_out} !== want) begin
            n_err++; $display("FAIL basic_count%0d got %b want %b", i, {busy, done, tc, cnt_out}, want);
         end
      end
      ack = 1'b1;
      step();
      ack = 1'b0;
      n_cmp++;
      if ({busy, done, tc, cnt_out} !== {3'b000, 5'd0}) begin
         n_err++; $display("FAIL basic_ack got %b want idle/0", {busy, done, tc, cnt_out});
      end
   endtask

   task automatic test_prescale();
      int n;
      prescale = 4'd2; enab = 1'b1; reload = 1'b0;
      do_load(2);
      do_start();
      n = 0;
      while (n < 50) begin
         step(); n++;
         if (n == 3) begin
            n_cmp++;
            if (cnt_out !== 5'd1) begin
               n_err++; $display("FAIL presc_mid got %0d want 1", cnt_out);
            end
         end
         if (tc) break;
      end
      n_cmp++;
      if (n != 6 || !done) begin
         n_err++; $display("FAIL presc_latency got %0d cycles done=%b want 6 done=1", n, done);
      end
      do_load(2);
      do_start();
      step(); step();
      enab = 1'b0;
      repeat (4) step();
      n_cmp++;
      if (cnt_out !== 5'd2 || !busy) begin
         n_err++; $display("FAIL presc_freeze got cnt=%0d busy=%b want 2/1", cnt_out, busy);
      end
      enab = 1'b1;
      n = 6;
      while (n < 50) begin
         step(); n++;
         if (tc) break;
      end
      n_cmp++;
      if (n != 10) begin
         n_err++; $display("FAIL presc_pause_latency got %0d want 10", n);
      end
   endtask

   task automatic test_reload();
      logic [WIDTH+2:0] want;
      prescale = '0; enab = 1'b1; reload = 1'b1;
      do_load(2);
      do_start();
      for (int i = 1; i <= 8; i++) begin
         step();
         want = (i % 2 == 0) ? {3'b101, 5'd2} : {3'b100, 5'd1};
         n_cmp++;
         if ({busy, done, tc, cnt_out} !== want) begin
            n_err++; $display("FAIL reload_seq%0d got %b want %b", i, {busy, done, tc, cnt_out}, want);
         end
      end
      reload = 1'b0;
      step(); step();
      n_cmp++;
      if ({busy, done, tc, cnt_out} !== {3'b011, 5'd0}) begin
         n_err++; $display("FAIL reload_drop got %b want done/tc/0", {busy, done, tc, cnt_out});
      end
   endtask

   task automatic test_zero_and_priority();
      do_load(0);
      do_start();
      n_cmp++;
      if ({busy, done, tc, cnt_out} !== {3'b011, 5'd0}) begin
         n_err++; $display("FAIL zero_start got %b want done/tc", {busy, done, tc, cnt_out});
      end
      step();
      n_cmp++;
      if ({busy, done, tc} !== 3'b010) begin
         n_err++; $display("FAIL zero_single_tc got %b want 010", {busy, done, tc});
      end
      load = 1'b1; start = 1'b1; ack = 1'b1; cnt_in = 5'd5;
      step();
      load = 1'b0; start = 1'b0; ack = 1'b0;
      n_cmp++;
      if ({busy, done, tc, cnt_out} !== {3'b000, 5'd5}) begin
         n_err++; $display("FAIL load_priority got %b want idle/5", {busy, done, tc, cnt_out});
      end
      step();
      n_cmp++;
      if ({busy, done, tc, cnt_out} !== {3'b000, 5'd5}) begin
         n_err++; $display("FAIL load_priority_hold got %b want idle/5", {busy, done, tc, cnt_out});
      end
   endtask

   task automatic test_async_reset();
      prescale = '0; enab = 1'b0; reload = 1'b0;
      do_load(17);
      do_start();
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({busy, done, tc, cnt_out} !== '0) begin
         n_err++; $display("FAIL async_reset got %b want 0 before edge", {busy, done, tc, cnt_out});
      end
      step();
      rst = 1'b0;
      enab = 1'b1;
      step();
      n_cmp++;
      if ({busy, done, tc, cnt_out} !== '0) begin
         n_err++; $display("FAIL async_reset_after got %b want 0", {busy, done, tc, cnt_out});
      end
   endtask

   task automatic test_width();
      int n;
      logic [WIDTH-1:0] prev;
      bit rose;
      prescale = 4'd15; enab = 1'b1; reload = 1'b0;
      do_load(31);
      do_start();
      n = 0; rose = 0; prev = cnt_out;
      while (n < 1000) begin
         step(); n++;
         if (cnt_out > prev) rose = 1;
         prev = cnt_out;
         if (tc) break;
      end
      n_cmp++;
      if (n != 31 * 16 || rose || cnt_out !== 5'd0) begin
         n_err++; $display("FAIL width_boundary got %0d cycles rose=%b cnt=%0d want 496/0/0", n, rose, cnt_out);
      end
      ack = 1'b1;
      step();
      ack = 1'b0;
   endtask

   task automatic test_random();
      int bad;
      bad = 0;
      for (int i = 0; i < 4000; i++) begin
         load     = ($urandom_range(0, 31) == 0);
         start    = ($urandom_range(0, 3) == 0);
         ack      = ($urandom_range(0, 7) == 0);
         enab     = ($urandom_range(0, 3) != 0);
         reload   = $urandom_range(0, 1) == 1;
         prescale = ($urandom_range(0, 15) == 0) ? PRE_W'($urandom_range(0, 15))
                                                 : PRE_W'($urandom_range(0, 3));
         cnt_in   = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom_range(0, 31))
                                                : WIDTH'($urandom_range(0, 7));
         rst      = ($urandom_range(0, 499) == 0);
         step();
         n_cmp++;
         if ({busy, done, tc, cnt_out} !== model_vec()) begin
            n_err++;
            if (bad < 10) $display("FAIL random_cycle%0d got %b want %b", i, {busy, done, tc, cnt_out}, model_vec());
            bad++;
         end
      end
      rst = 1'b0; load = 1'b0; start = 1'b0; ack = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_prescale();
      test_reload();
      test_zero_and_priority();
      test_async_reset();
      test_width();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
